// File: rtl/ysyx_22050243_alu_issue.sv
// ALU issue stage: decodes RV64I integer ALU instructions, selects operands
// and presents a registered {a, b, alu_ctrl, rd} bundle to the ALU.
// A one-entry skid buffer keeps in_ready purely registered while still
// sustaining one bundle per cycle under downstream backpressure.
module ysyx_22050243_alu_issue #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  output logic [4:0]       rd,
  output logic             rd_wen,
  output logic             illegal
);

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       ctrl;
    logic [4:0]       rd;
    logic             wen;
    logic             ill;
  } bundle_t;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [WIDTH-1:0] i_imm;
  logic [WIDTH-1:0] u_imm;
  logic [WIDTH-1:0] shamt6;
  logic [WIDTH-1:0] shamt5;
  bundle_t          dec;

  // Register-index field of rs1 is resolved upstream; only its data is used here.
  logic unused_rs1_field;
  assign unused_rs1_field = ^inst[19:15];

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign i_imm  = {{(WIDTH-12){inst[31]}}, inst[31:20]};
  assign u_imm  = {{(WIDTH-32){inst[31]}}, inst[31:12], 12'b0};
  assign shamt6 = {{(WIDTH-6){1'b0}}, inst[25:20]};
  assign shamt5 = {{(WIDTH-5){1'b0}}, inst[24:20]};

  // Decode the incoming instruction into an ALU bundle.
  always_comb begin
    dec      = '0;
    dec.a    = rs1_data;
    dec.b    = rs2_data;
    dec.ctrl = 4'b0000;
    dec.ill  = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          dec.ctrl = {1'b0, funct3};
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec.ctrl = 4'b1000;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec.ctrl = 4'b1101;
        end else begin
          dec.ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.b    = i_imm;
        dec.ctrl = {1'b0, funct3};
        if (funct3 == 3'b001) begin
          dec.b = shamt6;
          if (inst[31:26] != 6'b000000) dec.ill = 1'b1;
        end else if (funct3 == 3'b101) begin
          dec.b = shamt6;
          if (inst[31:26] == 6'b010000)      dec.ctrl = 4'b1101;
          else if (inst[31:26] != 6'b000000) dec.ill  = 1'b1;
        end
      end
      OPC_OP_32: begin
        if (funct3 == 3'b000 && funct7 == F7_BASE)      dec.ctrl = 4'b1001;
        else if (funct3 == 3'b000 && funct7 == F7_ALT)  dec.ctrl = 4'b1010;
        else if (funct3 == 3'b001 && funct7 == F7_BASE) dec.ctrl = 4'b1011;
        else if (funct3 == 3'b101 && funct7 == F7_BASE) dec.ctrl = 4'b1100;
        else if (funct3 == 3'b101 && funct7 == F7_ALT)  dec.ctrl = 4'b1110;
        else                                            dec.ill  = 1'b1;
      end
      OPC_OP_IMM_32: begin
        if (funct3 == 3'b000) begin
          dec.b    = i_imm;
          dec.ctrl = 4'b1001;
        end else begin
          dec.b = shamt5;
          if (funct3 == 3'b001 && funct7 == F7_BASE)      dec.ctrl = 4'b1011;
          else if (funct3 == 3'b101 && funct7 == F7_BASE) dec.ctrl = 4'b1100;
          else if (funct3 == 3'b101 && funct7 == F7_ALT)  dec.ctrl = 4'b1110;
          else                                            dec.ill  = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.a = '0;
        dec.b = u_imm;
      end
      OPC_AUIPC: begin
        dec.a = pc;
        dec.b = u_imm;
      end
      default: dec.ill = 1'b1;
    endcase
    // Illegal bundles still flow, but must not drive the ALU or write back.
    if (dec.ill) dec.ctrl = 4'b0000;
    dec.rd  = inst[11:7];
    dec.wen = ~dec.ill && (inst[11:7] != 5'd0);
  end

  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  logic    out_valid_q, out_valid_d;
  logic    skid_valid_q, skid_valid_d;
  logic    in_xfer;
  logic    out_load;

  assign in_ready = ~skid_valid_q;
  assign in_xfer  = in_valid && ~skid_valid_q;
  assign out_load = ~out_valid_q || out_ready;

  // Next-state for output register and skid entry; flush overrides everything.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_load) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      // Output is stalled: park the new bundle so ordering stays FIFO.
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_a     = out_q.a;
  assign alu_b     = out_q.b;
  assign alu_ctrl  = out_q.ctrl;
  assign rd        = out_q.rd;
  assign rd_wen    = out_q.wen;
  assign illegal   = out_q.ill;

endmodule

// File: tb/tb_ysyx_22050243_alu_issue.sv
// Directed bench for the ALU issue stage: table of decode vectors plus
// hand-written sequences for backpressure, flush and asynchronous reset.
module tb_ysyx_22050243_alu_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [63:0] pc;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rd;
  logic        rd_wen;
  logic        illegal;

  int checks;
  int failures;

  ysyx_22050243_alu_issue #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .rd(rd),
    .rd_wen(rd_wen), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] p,
                       input logic [63:0] r1, input logic [63:0] r2);
    in_valid = v;
    inst     = i;
    pc       = p;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic [63:0] p, input logic [63:0] r1,
                              input logic [63:0] r2, input logic [63:0] a, input logic [63:0] b,
                              input logic [3:0] c, input logic [4:0] d, input logic w, input logic il);
    vec_t v;
    v.inst = i; v.pc = p; v.rs1 = r1; v.rs2 = r2; v.a = a; v.b = b;
    v.ctrl = c; v.rd = d; v.wen = w; v.ill = il;
    return v;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0]  = mk(32'h002081B3, 64'h1000, 64'd5, 64'd7, 64'd5, 64'd7, 4'b0000, 5'd3, 1'b1, 1'b0);           // add
    vecs[1]  = mk(32'h43F35293, 64'h1004, 64'h8000000000000000, 64'd1, 64'h8000000000000000, 64'd63, 4'b1101, 5'd5, 1'b1, 1'b0); // srai 63
    vecs[2]  = mk(32'hFFF0809B, 64'h1008, 64'd10, 64'd3, 64'd10, 64'hFFFFFFFFFFFFFFFF, 4'b1001, 5'd1, 1'b1, 1'b0); // addiw -1
    vecs[3]  = mk(32'h123450B7, 64'h100C, 64'hDEAD, 64'hBEEF, 64'd0, 64'h12345000, 4'b0000, 5'd1, 1'b1, 1'b0);  // lui
    vecs[4]  = mk(32'h12345097, 64'h80000000, 64'hDEAD, 64'hBEEF, 64'h80000000, 64'h12345000, 4'b0000, 5'd1, 1'b1, 1'b0); // auipc
    vecs[5]  = mk(32'hFFFFF0B7, 64'h1010, 64'd1, 64'd2, 64'd0, 64'hFFFFFFFFFFFFF000, 4'b0000, 5'd1, 1'b1, 1'b0); // lui negative
    vecs[6]  = mk(32'h402081B3, 64'h1014, 64'd9, 64'd4, 64'd9, 64'd4, 4'b1000, 5'd3, 1'b1, 1'b0);           // sub
    vecs[7]  = mk(32'h0020B1B3, 64'h1018, 64'd9, 64'd4, 64'd9, 64'd4, 4'b0011, 5'd3, 1'b1, 1'b0);           // sltu
    vecs[8]  = mk(32'hFFB00093, 64'h101C, 64'd0, 64'd4, 64'd0, 64'hFFFFFFFFFFFFFFFB, 4'b0000, 5'd1, 1'b1, 1'b0); // addi -5
    vecs[9]  = mk(32'h4020D1BB, 64'h1020, 64'h55, 64'h66, 64'h55, 64'h66, 4'b1110, 5'd3, 1'b1, 1'b0);       // sraw
    vecs[10] = mk(32'h01F0909B, 64'h1024, 64'h77, 64'h66, 64'h77, 64'd31, 4'b1011, 5'd1, 1'b1, 1'b0);      // slliw 31
    vecs[11] = mk(32'h02009093, 64'h1028, 64'h77, 64'h66, 64'h77, 64'd32, 4'b0001, 5'd1, 1'b1, 1'b0);      // slli 32
    vecs[12] = mk(32'h0000007F, 64'h102C, 64'd1, 64'd2, 64'd0, 64'd0, 4'b0000, 5'd0, 1'b0, 1'b1);          // bad opcode
    vecs[13] = mk(32'h022081B3, 64'h1030, 64'd1, 64'd2, 64'd0, 64'd0, 4'b0000, 5'd3, 1'b0, 1'b1);          // mul (funct7 1)
    vecs[14] = mk(32'h00208033, 64'h1034, 64'd5, 64'd7, 64'd5, 64'd7, 4'b0000, 5'd0, 1'b0, 1'b0);          // add x0
    vecs[15] = mk(32'h03F0909B, 64'h1038, 64'd1, 64'd2, 64'd0, 64'd0, 4'b0000, 5'd1, 1'b0, 1'b1);          // slliw bit25
    vecs[16] = mk(32'h0020A1BB, 64'h103C, 64'd1, 64'd2, 64'd0, 64'd0, 4'b0000, 5'd3, 1'b0, 1'b1);          // OP-32 f3=010
    vecs[17] = mk(32'h0440D093, 64'h1040, 64'd1, 64'd2, 64'd0, 64'd0, 4'b0000, 5'd1, 1'b0, 1'b1);          // srli bad hi
    vecs[18] = mk(32'h0020D1BB, 64'h1044, 64'h11, 64'h22, 64'h11, 64'h22, 4'b1100, 5'd3, 1'b1, 1'b0);      // srlw
    vecs[19] = mk(32'h0020C1B3, 64'h1048, 64'h11, 64'h22, 64'h11, 64'h22, 4'b0100, 5'd3, 1'b1, 1'b0);      // xor

    // Reset state.
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_bundle", {alu_a ^ alu_b, 50'd0, alu_ctrl, rd, rd_wen, illegal},
          {64'd0, 50'd0, 4'd0, 5'd0, 1'b0, 1'b0});
    check("reset_alu_a", alu_a, 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
    $display("reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);

    // Table-driven decode vectors, back-to-back with out_ready=1.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].inst, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("vec%0d_ctrl", i), {60'd0, alu_ctrl}, {60'd0, vecs[i].ctrl});
      check($sformatf("vec%0d_rd", i), {59'd0, rd}, {59'd0, vecs[i].rd});
      check($sformatf("vec%0d_flags", i), {62'd0, rd_wen, illegal}, {62'd0, vecs[i].wen, vecs[i].ill});
      if (!vecs[i].ill) begin
        check($sformatf("vec%0d_a", i), alu_a, vecs[i].a);
        check($sformatf("vec%0d_b", i), alu_b, vecs[i].b);
      end
      $display("vec%0d inst=%08h ctrl=%04b a=%0h b=%0h rd=%0d wen=%0d ill=%0d",
               i, vecs[i].inst, alu_ctrl, alu_a, alu_b, rd, rd_wen, illegal);
    end
    @(negedge clk) drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
    @(posedge clk); #1;
    check("idle_out_valid", {63'd0, out_valid}, 64'd0);

    // Backpressure: A held, B in skid, C waits upstream; then drain in order.
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 64'h0, 64'hA, 64'h1);     // A: add x3
    @(posedge clk); #1;
    check("bp_A_loaded", {63'd0, out_valid}, 64'd1);
    @(negedge clk) drive(1'b1, 32'h402081B3, 64'h0, 64'hB, 64'h2); // B: sub x3
    @(posedge clk); #1;
    check("bp_skid_full_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk) drive(1'b1, 32'h0020C1B3, 64'h0, 64'hC, 64'h3); // C: xor x3
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_a", k), alu_a, 64'hA);
      check($sformatf("bp_hold%0d_ctrl", k), {60'd0, alu_ctrl}, 64'd0);
      check($sformatf("bp_hold%0d_in_ready", k), {63'd0, in_ready}, 64'd0);
      $display("hold%0d: a=%0h ctrl=%04b in_ready=%0d", k, alu_a, alu_ctrl, in_ready);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_B_a", alu_a, 64'hB);
    check("drain_B_ctrl", {60'd0, alu_ctrl}, 64'd8);
    check("drain_B_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    check("drain_C_a", alu_a, 64'hC);
    check("drain_C_ctrl", {60'd0, alu_ctrl}, 64'd4);
    @(negedge clk) drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
    @(posedge clk); #1;
    check("drain_empty", {63'd0, out_valid}, 64'd0);
    $display("drain: A,B,C presented in order, then out_valid=%0d", out_valid);

    // Flush with both entries full and a same-cycle input.
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 64'h0, 64'h1, 64'h1);
    @(negedge clk) drive(1'b1, 32'h002081B3, 64'h0, 64'h2, 64'h2);
    @(negedge clk);
    check("flush_pre_in_ready", {63'd0, in_ready}, 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h002081B3, 64'h0, 64'h3, 64'h3);
    @(posedge clk); #1;
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
    @(posedge clk); #1;
    check("flush_nothing_left", {63'd0, out_valid}, 64'd0);
    $display("flush: out_valid=%0d in_ready=%0d", out_valid, in_ready);

    // Asynchronous reset mid-stream.
    @(negedge clk) drive(1'b1, 32'h123450B7, 64'h0, 64'h0, 64'h0);
    @(posedge clk); #1;
    check("mid_pre_valid", {63'd0, out_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_alu_b", alu_b, 64'd0);
    check("mid_rst_flags", {58'd0, rd, rd_wen}, 64'd0);
    $display("async reset: out_valid=%0d alu_b=%0h rd=%0d", out_valid, alu_b, rd);
    @(negedge clk) rst = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
    @(posedge clk); #1;
    check("post_mid_rst_idle", {62'd0, out_valid, in_ready}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
